// File: rtl/key_schedule_reader_pkg.sv
// Shared constants, FSM state type and GF(2^8) helpers for the key-schedule reader.
package key_schedule_reader_pkg;

    localparam int         NB      = 4;
    localparam logic [7:0] NK_128  = 8'd4;
    localparam logic [7:0] NK_192  = 8'd6;
    localparam logic [7:0] NK_256  = 8'd8;
    localparam int         MAX_NR  = 14;
    localparam int         IDX_W   = $clog2(MAX_NR + 1);
    localparam int         W_WIDTH = 1920;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_KEY,
        SERVE
    } state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = '0;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = xtime(x);
        end
        return acc;
    endfunction

endpackage

// File: rtl/key_schedule_reader_inv_mix.sv
// InvMixColumns on one 32-bit state column (byte 0 in the most significant position).
module inv_mix_column_word (
    input  logic [31:0] col_i,
    output logic [31:0] col_o
);
    import key_schedule_reader_pkg::*;

    logic [7:0] a0, a1, a2, a3;

    assign {a0, a1, a2, a3} = col_i;

    assign col_o[31:24] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
    assign col_o[23:16] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
    assign col_o[15:8]  = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
    assign col_o[7:0]   = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);

endmodule

// File: rtl/key_schedule_reader.sv
// Captures the expanded AES key schedule and serves one round key per handshake, forward or reverse.
// Define EQUIV_INV_CIPHER_EN to present InvMixColumns'd middle keys in decrypt mode.
module key_schedule_reader #(
    parameter int W_WIDTH  = key_schedule_reader_pkg::W_WIDTH,
    parameter int RK_WIDTH = 128
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [W_WIDTH-1:0]  w,
    input  logic                done,
    input  logic [7:0]          Nk,
    input  logic                start,
    input  logic                decrypt,
    input  logic                rk_ready,
    output logic                rk_valid,
    output logic [RK_WIDTH-1:0] rk_data,
    output logic [3:0]          rk_round,
    output logic                rk_last,
    output logic                busy,
    output logic                err
);
    import key_schedule_reader_pkg::*;

    localparam int NKEYS = W_WIDTH / RK_WIDTH;

    state_e             state_q;
    logic [W_WIDTH-1:0] cap_q;
    logic [IDX_W-1:0]   nr_q;
    logic [IDX_W-1:0]   idx_q;
    logic               dec_q;
    logic               busy_q;
    logic               err_q;

    logic [IDX_W-1:0]    nr_d;
    logic [IDX_W-1:0]    idx_d;
    logic [IDX_W-1:0]    end_idx;
    logic                nk_legal;
    logic [RK_WIDTH-1:0] keys [NKEYS];
    logic [RK_WIDTH-1:0] raw_key;
    logic [RK_WIDTH-1:0] out_key;

    assign nk_legal = (Nk == NK_128) || (Nk == NK_192) || (Nk == NK_256);
    assign nr_d     = Nk[IDX_W-1:0] + 4'd6;
    assign idx_d    = dec_q ? (idx_q - 4'd1) : (idx_q + 4'd1);
    assign end_idx  = dec_q ? '0 : nr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cap_q   <= '0;
            nr_q    <= '0;
            idx_q   <= '0;
            dec_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (nk_legal) begin
                            nr_q    <= nr_d;
                            dec_q   <= decrypt;
                            busy_q  <= 1'b1;
                            state_q <= WAIT_KEY;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                WAIT_KEY: begin
                    // Snapshot the schedule once; later changes to w or done are ignored.
                    if (done) begin
                        cap_q   <= w;
                        idx_q   <= dec_q ? nr_q : '0;
                        state_q <= SERVE;
                    end
                end
                SERVE: begin
                    if (rk_ready) begin
                        if (rk_last) begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            idx_q <= idx_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar r = 0; r < NKEYS; r++) begin : g_key
        assign keys[r] = cap_q[W_WIDTH-1-RK_WIDTH*r -: RK_WIDTH];
    end

    assign raw_key = keys[idx_q];

`ifdef EQUIV_INV_CIPHER_EN
    logic [RK_WIDTH-1:0] imc_key;
    logic                use_imc;

    for (genvar c = 0; c < NB; c++) begin : g_imc
        inv_mix_column_word u_imc (
            .col_i (raw_key[RK_WIDTH-1-32*c -: 32]),
            .col_o (imc_key[RK_WIDTH-1-32*c -: 32])
        );
    end

    // Equivalent inverse cipher: only the inner rounds are transformed.
    assign use_imc = dec_q && (idx_q != '0) && (idx_q != nr_q);
    assign out_key = use_imc ? imc_key : raw_key;
`else
    assign out_key = raw_key;
`endif

    assign rk_valid = (state_q == SERVE);
    assign rk_data  = rk_valid ? out_key : '0;
    assign rk_round = rk_valid ? idx_q : '0;
    assign rk_last  = rk_valid && (idx_q == end_idx);
    assign busy     = busy_q;
    assign err      = err_q;

endmodule

// File: tb/tb_key_schedule_reader.sv
// Directed bench for key_schedule_reader: FIPS-197 key expansions feed a round-key scoreboard.
module tb_key_schedule_reader;

    logic          clk = 1'b0;
    logic          reset;
    logic [1919:0] w;
    logic          done;
    logic [7:0]    Nk;
    logic          start;
    logic          decrypt;
    logic          rk_ready;
    logic          rk_valid;
    logic [127:0]  rk_data;
    logic [3:0]    rk_round;
    logic          rk_last;
    logic          busy;
    logic          err;

    key_schedule_reader dut (
        .clk      (clk),
        .reset    (reset),
        .w        (w),
        .done     (done),
        .Nk       (Nk),
        .start    (start),
        .decrypt  (decrypt),
        .rk_ready (rk_ready),
        .rk_valid (rk_valid),
        .rk_data  (rk_data),
        .rk_round (rk_round),
        .rk_last  (rk_last),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [127:0] data;
        logic [3:0]   round;
        logic         last;
    } exp_t;

    int            vectors     = 0;
    int            miscompares = 0;
    int            hs_count    = 0;
    bit            chk_en      = 1'b0;
    bit            exp_busy    = 1'b0;
    bit            exp_err     = 1'b0;
    bit            stall_pend  = 1'b0;
    logic [131:0]  stall_val;
    logic [31:0]   ww [60];
    logic [1919:0] bus;
    exp_t          exp_q [$];
    exp_t          cur;
    logic [127:0]  got_key [15];
    logic [3:0]    got_last_round;

    // ---------------- reference model: AES arithmetic and key expansion ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p = 8'h00; aa = a; bb = b;
        while (bb != 8'h00) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    // S-box as multiplicative inverse (x^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] p;
        inv = 8'h01;
        p   = gmul(x, x);
        for (int k = 1; k < 8; k++) begin
            inv = gmul(inv, p);
            p   = gmul(p, p);
        end
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    function automatic logic [31:0] imc_col(input logic [31:0] c);
        logic [7:0] a [4];
        logic [7:0] m [4];
        logic [7:0] o [4];
        a[0] = c[31:24]; a[1] = c[23:16]; a[2] = c[15:8]; a[3] = c[7:0];
        m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
        for (int j = 0; j < 4; j++) begin
            o[j] = 8'h00;
            for (int k = 0; k < 4; k++) o[j] = o[j] ^ gmul(a[k], m[(k - j + 4) % 4]);
        end
        return {o[0], o[1], o[2], o[3]};
    endfunction

    function automatic logic [127:0] imc_key(input logic [127:0] k);
        return {imc_col(k[127:96]), imc_col(k[95:64]), imc_col(k[63:32]), imc_col(k[31:0])};
    endfunction

    task automatic expand(input logic [255:0] key, input int nk);
        logic [31:0] t;
        logic [7:0]  rcon;
        for (int i = 0; i < 60; i++) ww[i] = 32'h0;
        for (int i = 0; i < nk; i++) ww[i] = key[255-32*i -: 32];
        rcon = 8'h01;
        for (int i = nk; i < 4 * (nk + 7); i++) begin
            t = ww[i-1];
            if (i % nk == 0) begin
                t    = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            ww[i] = ww[i-nk] ^ t;
        end
        for (int i = 0; i < 60; i++) bus[1919-32*i -: 32] = ww[i];
    endtask

    function automatic logic [127:0] model_key(input int r);
        return {ww[4*r], ww[4*r+1], ww[4*r+2], ww[4*r+3]};
    endfunction

    task automatic push_exp(input int nr, input bit dec);
        for (int n = 0; n <= nr; n++) begin
            int   r;
            exp_t e;
            r      = dec ? (nr - n) : n;
            e.data = model_key(r);
`ifdef EQUIV_INV_CIPHER_EN
            if (dec && r != 0 && r != nr) e.data = imc_key(e.data);
`endif
            e.round = 4'(r);
            e.last  = (n == nr);
            exp_q.push_back(e);
        end
    endtask

    task automatic chk(input string name, input logic [131:0] act, input logic [131:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 132'(busy), 132'(exp_busy));
            chk("err", 132'(err), 132'(exp_err));
            if (stall_pend && rk_valid)
                chk("stall_hold", {rk_round, rk_data}, stall_val);
            stall_pend = 1'b0;
            if (rk_valid) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious_valid: got rk_round=%0d expected no key", rk_round);
                end else begin
                    cur = exp_q[0];
                    chk("rk_data", 132'(rk_data), 132'(cur.data));
                    chk("rk_round", 132'(rk_round), 132'(cur.round));
                    chk("rk_last", 132'(rk_last), 132'(cur.last));
                    if (rk_ready) begin
                        hs_count++;
                        if (rk_round <= 4'd14) got_key[rk_round] = rk_data;
                        if (rk_last) got_last_round = rk_round;
                        void'(exp_q.pop_front());
                        if (exp_q.size() == 0) exp_busy = 1'b0;
                    end else begin
                        stall_pend = 1'b1;
                        stall_val  = {rk_round, rk_data};
                    end
                end
            end else begin
                chk("rk_last_idle", 132'(rk_last), 132'(0));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_start(input logic [7:0] nk, input logic dec, input bit legal);
        @(posedge clk); #1;
        Nk = nk; decrypt = dec; start = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        hs_count = 0;
        for (int r = 0; r < 15; r++) got_key[r] = '0;
        got_last_round = 4'hf;
        if (legal) begin
            exp_busy = 1'b1;
            push_exp(int'(nk) + 6, dec);
        end else begin
            exp_err = 1'b1;
        end
    endtask

    // done already high at start: one idle edge, then the first key.
    task automatic first_key_checks(input logic [3:0] rnd, input logic [127:0] key);
        @(negedge clk);
        chk("valid_before_capture", 132'(rk_valid), 132'(0));
        @(negedge clk);
        chk("valid_after_capture", 132'(rk_valid), 132'(1));
        chk("first_round", 132'(rk_round), 132'(rnd));
        chk("first_key", 132'(rk_data), 132'(key));
    endtask

    task automatic wait_done(input bit rnd, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_busy) && n < budget) begin
            @(posedge clk); #1;
            if (rnd) rk_ready = 1'($urandom_range(0, 1));
            n++;
        end
        if (exp_q.size() != 0 || exp_busy) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout: got %0d keys outstanding expected 0", exp_q.size());
            exp_q.delete();
            exp_busy = 1'b0;
        end
        rk_ready = 1'b1;
        @(negedge clk);
        chk("busy_after_read", 132'(busy), 132'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected end of test");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [255:0] k128, k192, k256;
        k128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        k192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
        k256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

        reset = 1'b0; w = '0; done = 1'b0; Nk = 8'd4; start = 1'b0;
        decrypt = 1'b0; rk_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {rk_valid, rk_last, busy, err, rk_round, rk_data},
            132'(0) << 0);
        reset = 1'b1;
        chk_en = 1'b1;

        // AES-128 forward, done already high
        expand(k128, 4);
        w = bus; done = 1'b1;
        do_start(8'd4, 1'b0, 1'b1);
        first_key_checks(4'd0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        wait_done(1'b0, 40);
        chk("aes128_r10", 132'(got_key[10]), 132'(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
        chk("aes128_last_round", 132'(got_last_round), 132'(10));
        chk("aes128_handshakes", 132'(hs_count), 132'(11));

        // AES-192 reverse, done raised late, junk inputs after start
        expand(k192, 6);
        w = bus; done = 1'b0;
        do_start(8'd6, 1'b1, 1'b1);
        Nk = 8'd5; decrypt = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        done = 1'b1;
        @(negedge clk);
        chk("valid_before_done_edge", 132'(rk_valid), 132'(0));
        @(negedge clk);
        chk("valid_after_done_edge", 132'(rk_valid), 132'(1));
        chk("aes192_first_round", 132'(rk_round), 132'(12));
        chk("aes192_first_key", 132'(rk_data), 132'(128'he98ba06f448c773c8ecc720401002202));
        done = 1'b0;
        for (int i = 0; i < 60; i++) w[1919-32*i -: 32] = $urandom();
        wait_done(1'b0, 40);
        chk("aes192_r0", 132'(got_key[0]), 132'(128'h8e73b0f7da0e6452c810f32b809079e5));
        chk("aes192_last_round", 132'(got_last_round), 132'(0));
        chk("aes192_handshakes", 132'(hs_count), 132'(13));

        // AES-256 forward with random back-pressure
        expand(k256, 8);
        w = bus; done = 1'b1; rk_ready = 1'b0;
        do_start(8'd8, 1'b0, 1'b1);
        wait_done(1'b1, 300);
        chk("aes256_r14", 132'(got_key[14]), 132'(128'hfe4890d1e6188d0b046df344706c631e));
        chk("aes256_handshakes", 132'(hs_count), 132'(15));

        // Illegal key length
        do_start(8'd5, 1'b0, 1'b0);
        @(negedge clk);
        chk("err_pulse", 132'(err), 132'(1));
        chk("err_no_busy", 132'(busy), 132'(0));
        @(posedge clk); #1;
        exp_err = 1'b0;
        @(negedge clk);
        chk("err_cleared", 132'(err), 132'(0));
        chk("err_no_valid", 132'(rk_valid), 132'(0));

        // Reset during SERVE at round 3, then restart
        expand(k128, 4);
        w = bus; done = 1'b1;
        do_start(8'd4, 1'b0, 1'b1);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (rk_valid && rk_round == 4'd3) break;
        end
        chk("reached_round3", 132'(rk_round), 132'(3));
        #2;
        chk_en = 1'b0;
        reset  = 1'b0;
        #1;
        chk("async_reset_outputs", {rk_valid, rk_last, busy, err, rk_round, rk_data}, 132'(0));
        exp_q.delete();
        exp_busy = 1'b0; stall_pend = 1'b0;
        @(negedge clk);
        reset  = 1'b1;
        chk_en = 1'b1;
        do_start(8'd4, 1'b0, 1'b1);
        first_key_checks(4'd0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        wait_done(1'b0, 40);
        chk("restart_handshakes", 132'(hs_count), 132'(11));

        // AES-128 reverse (equivalent inverse keys when the option is built in)
        do_start(8'd4, 1'b1, 1'b1);
        first_key_checks(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        wait_done(1'b0, 40);
        chk("dec128_r0", 132'(got_key[0]), 132'(128'h2b7e151628aed2a6abf7158809cf4f3c));
`ifdef EQUIV_INV_CIPHER_EN
        chk("dec128_r9_equiv", 132'(got_key[9]),
            132'(imc_key(128'hac7766f319fadc2128d12941575c006e)));
`else
        chk("dec128_r9_raw", 132'(got_key[9]), 132'(128'hac7766f319fadc2128d12941575c006e));
`endif
        chk("dec128_handshakes", 132'(hs_count), 132'(11));

        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/key_schedule_reader.md
Name: key_schedule_reader

Overview:
- Consumer end of the key-expansion interface. The expander writes the flat word bus and raises its done flag; this block captures the expanded schedule and serves one 128-bit round key per handshake.
- Serves keys to the cipher datapath in forward order (encrypt, round 0..Nr) or reverse order (decrypt, round Nr..0).
- Sits between the key-expansion unit and the round datapath. It decouples the two so the expander can be re-keyed while the captured schedule is being consumed.

Parameters:
- W_WIDTH, 1920, width of the expanded-key bus (60 words x 32 bits, worst case AES-256).
- RK_WIDTH, 128, round-key width (Nb=4 words).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- w  input  W_WIDTH  expanded key words from the key-expansion unit; word i = w[W_WIDTH-1-32*i -: 32].
- done  input  1  key-expansion done flag (level); w is valid while high.
- Nk  input  8  key length in words; legal values 4, 6, 8.
- start  input  1  one-cycle request to begin a schedule read.
- decrypt  input  1  0 = forward order, 1 = reverse order; sampled with start.
- rk_ready  input  1  consumer ready.
- rk_valid  output  1  rk_data valid.
- rk_data  output  RK_WIDTH  round key r = w[W_WIDTH-1-128*r -: 128].
- rk_round  output  4  index r of the key on rk_data.
- rk_last  output  1  high with the final key of the sequence.
- busy  output  1  high from accepted start until the last handshake.
- err  output  1  one-cycle pulse on start with illegal Nk.

Behaviour:
- Reset values: all outputs 0; FSM = IDLE; capture register cleared.
- Nr = Nk + 6, computed from Nk latched at start. 4->10, 6->12, 8->14.
- IDLE state:
  - On start with legal Nk: latch Nk and decrypt, set busy, go to WAIT_KEY.
  - On start with illegal Nk: err=1 for one cycle, stay in IDLE, busy stays 0.
- WAIT_KEY state:
  - On the first edge with done=1, register w into the capture buffer.
  - Set idx = 0 (forward) or Nr (reverse), go to SERVE.
  - rk_valid rises on the cycle after done is sampled high. If done is already high when start is accepted, capture occurs on the next edge.
- SERVE state:
  - rk_valid=1; rk_data/rk_round reflect idx, driven combinationally from the capture buffer.
  - rk_data and rk_round hold stable while rk_valid && !rk_ready.
  - On rk_valid && rk_ready: idx increments (forward) or decrements (reverse).
  - rk_last=1 when idx==Nr (forward) or idx==0 (reverse).
  - Handshake on the last key: rk_valid=0, busy=0, go to IDLE on the next cycle.
  - No wrap-around; idx never leaves 0..Nr.
- Input-change rules:
  - start while busy: ignored, no err.
  - Nk/decrypt changes after start: ignored (latched values used).
  - done falling or w changing after capture: ignored.
- Reset asserted mid-operation: immediate return to IDLE; all outputs 0; the consumer must restart.
- Throughput: one key per cycle with rk_ready held high. A full AES-256 read takes 15 cycles after capture.

Optional Feature:
- Macro EQUIV_INV_CIPHER_EN.
- When defined, in decrypt mode the keys for rounds 1..Nr-1 are presented with InvMixColumns applied per 32-bit column, giving the FIPS-197 equivalent inverse cipher key set. Rounds 0 and Nr pass unmodified. Encrypt mode is unaffected.
- Transform is combinational on the output mux path; no extra latency.
- When undefined, keys are always raw and the InvMixColumns logic is absent.

Decomposition:
- Shared AES package holds:
  - constants NB=4, NK_128=4, NK_192=6, NK_256=8, MAX_NR=14, W_WIDTH=1920;
  - state enum {IDLE, WAIT_KEY, SERVE};
  - GF(2^8) xtime/multiply functions used by InvMixColumns.
- One sub-module: inv_mix_column_word (32-bit in, 32-bit out), instantiated 4x only under EQUIV_INV_CIPHER_EN.

Test Plan:
- AES-128, Nk=4, key 2b7e151628aed2a6abf7158809cf4f3c, decrypt=0, rk_ready=1:
  - round 0 = key;
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_last=1;
  - 11 handshakes total; busy drops after the last.
- AES-192, Nk=6, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, decrypt=1:
  - first key is round 12 = e98ba06f448c773c8ecc720401002202, rk_round=12;
  - last key is round 0 = 8e73b0f7da0e6452c810f32b809079e5 with rk_last=1.
- AES-256, Nk=8, key 603deb10…0914dff4, decrypt=0, rk_ready toggled randomly:
  - rk_data stable while stalled;
  - round 14 = fe4890d1e6188d0b046df344706c631e;
  - exactly 15 handshakes.
- start with Nk=5 -> single-cycle err pulse, busy stays 0, rk_valid stays 0.
- Reset driven low during SERVE at round 3 -> all outputs 0 immediately. A new start with done=1 captures and serves from round 0.
- With EQUIV_INV_CIPHER_EN, AES-128 decrypt:
  - round-9 key equals InvMixColumns of the raw round-9 key from the reference model;
  - round 10 and round 0 keys unmodified.
